// File: rtl/count_event_buffer.sv
// Watches a free-running count word, turns each value change into a {wrap, value}
// event and queues it in a first-word-fall-through FIFO behind a valid/ready port.
module count_event_buffer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int DROPW = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [WIDTH-1:0]           count_in,
  input  logic                       sample_en,
  input  logic                       out_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_wrap,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       overflow,
  output logic [DROPW-1:0]           drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH:0]     mem [DEPTH];
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      wr_ptr;
  logic [WIDTH-1:0]   prev_count;
  logic               prev_vld;
  logic               event_det;
  logic               pop;
  logic               push;
  logic               drop;

  assign out_valid = (level != '0);
  assign full      = (level == LW'(DEPTH));

  // Gate the head so an empty FIFO presents zeros rather than stale storage.
  assign out_data  = out_valid ? mem[rd_ptr][WIDTH-1:0] : '0;
  assign out_wrap  = out_valid ? mem[rd_ptr][WIDTH]     : 1'b0;

  assign event_det = sample_en && prev_vld && (count_in != prev_count);
  assign pop       = out_valid && out_ready;
  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign push      = event_det && (!full || pop);
  assign drop      = event_det && full && !pop;

  // NOTE: storage is not reset; level gates every read, so stale entries are never seen.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {(count_in < prev_count), count_in};
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rstn) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      level      <= '0;
      prev_count <= '0;
      prev_vld   <= 1'b0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      if (sample_en) begin
        prev_count <= count_in;
        prev_vld   <= 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + DROPW'(1);
      end
    end
  end

endmodule

// File: tb/tb_count_event_buffer.sv
// Self-checking bench for count_event_buffer: directed scenarios followed by random
// traffic, all compared every cycle against a queue-based reference model.
module tb_count_event_buffer;

  localparam int WIDTH = 4;
  localparam int DEPTH = 8;
  localparam int DROPW = 8;

  logic                   clk = 1'b0;
  logic                   rstn = 1'b1;
  logic [WIDTH-1:0]       count_in = '0;
  logic                   sample_en = 1'b0;
  logic                   out_ready = 1'b0;
  logic                   out_valid;
  logic [WIDTH-1:0]       out_data;
  logic                   out_wrap;
  logic [$clog2(DEPTH):0] level;
  logic                   full;
  logic                   overflow;
  logic [DROPW-1:0]       drop_count;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state: queue of {wrap, value} entries.
  logic [WIDTH:0] q[$];
  int             m_prev;
  bit             m_pvld;
  bit             m_ovf;
  int             m_drops;

  count_event_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DROPW(DROPW)) dut (
    .clk(clk), .rstn(rstn), .count_in(count_in), .sample_en(sample_en),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_wrap(out_wrap), .level(level), .full(full), .overflow(overflow),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input bit rst, input bit se, input int cin, input bit rdy);
    bit pop_ok;
    if (rst) begin
      q.delete();
      m_prev = 0; m_pvld = 0; m_ovf = 0; m_drops = 0;
      return;
    end
    pop_ok = (q.size() > 0) && rdy;
    if (pop_ok) void'(q.pop_front());
    if (se && m_pvld && cin != m_prev) begin
      if (q.size() < DEPTH) q.push_back({(cin < m_prev), 4'(cin)});
      else begin
        m_ovf = 1;
        if (m_drops < 2**DROPW - 1) m_drops++;
      end
    end
    if (se) begin
      m_prev = cin;
      m_pvld = 1;
    end
  endtask

  task automatic compare_all();
    int sz = q.size();
    check("level",      32'(level),      32'(sz));
    check("out_valid",  32'(out_valid),  32'(sz > 0));
    check("full",       32'(full),       32'(sz == DEPTH));
    check("out_data",   32'(out_data),   sz > 0 ? 32'(q[0][WIDTH-1:0]) : 32'd0);
    check("out_wrap",   32'(out_wrap),   sz > 0 ? 32'(q[0][WIDTH])     : 32'd0);
    check("overflow",   32'(overflow),   32'(m_ovf));
    check("drop_count", 32'(drop_count), 32'(m_drops));
  endtask

  // Drive inputs away from the rising edge, update the model, then sample #1 after it.
  task automatic step(input bit rst, input bit se, input int cin, input bit rdy);
    @(negedge clk);
    rstn      = rst;
    sample_en = se;
    count_in  = 4'(cin);
    out_ready = rdy;
    model_update(rst, se, cin, rdy);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    // Reset and priming
    step(1, 0, 0, 0);
    step(1, 1, 9, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 3, 0);
    check("prime_level", 32'(level), 32'd0);
    check("prime_valid", 32'(out_valid), 32'd0);

    // Increment sequence with one-cycle latency
    step(1, 0, 0, 0);
    step(0, 1, 0, 1);
    step(0, 1, 1, 1);
    check("inc_first_data", 32'(out_data), 32'd1);
    check("inc_first_valid", 32'(out_valid), 32'd1);
    step(0, 1, 2, 1);
    step(0, 1, 3, 1);
    check("inc_last_data", 32'(out_data), 32'd3);
    step(0, 0, 3, 1);
    check("inc_drained", 32'(level), 32'd0);

    // Wrap detection
    step(1, 0, 0, 0);
    step(0, 1, 13, 0);
    step(0, 1, 14, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    check("wrap_level", 32'(level), 32'd3);
    check("wrap_head", 32'({out_wrap, out_data}), 32'h0e);
    step(0, 0, 1, 1);
    check("wrap_entry", 32'({out_wrap, out_data}), 32'h10);
    step(0, 0, 1, 1);
    check("wrap_third", 32'({out_wrap, out_data}), 32'h01);
    step(0, 0, 1, 1);

    // Backpressure and overflow, then simultaneous push/pop while full
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    for (int v = 1; v <= 10; v++) step(0, 1, v, 0);
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_drops", 32'(drop_count), 32'd2);
    check("ovf_head", 32'(out_data), 32'd1);
    step(0, 1, 11, 1);
    check("pp_level", 32'(level), 32'd8);
    check("pp_drops", 32'(drop_count), 32'd2);
    for (int i = 0; i < 8; i++) step(0, 0, 11, 1);
    check("pp_empty", 32'(out_valid), 32'd0);
    check("pp_sticky", 32'(overflow), 32'd1);

    // Mid-operation reset
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    for (int v = 1; v <= 5; v++) step(0, 1, v, 0);
    check("mid_level5", 32'(level), 32'd5);
    step(1, 1, 6, 1);
    check("mid_rst_level", 32'(level), 32'd0);
    step(0, 1, 7, 0);
    check("mid_prime", 32'(out_valid), 32'd0);
    step(0, 1, 9, 0);
    check("mid_first_evt", 32'(out_data), 32'd9);

    // Random traffic with occasional resets
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 15), $urandom_range(0, 2) == 0);

    // Drop counter saturation
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 1; i <= 8 + 300; i++) step(0, 1, i % 16, 0);
    check("sat_drops", 32'(drop_count), 32'd255);
    for (int i = 0; i < 10; i++) step(0, 1, $urandom_range(0, 15), $urandom_range(0, 1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
